// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared UART constants, arbiter state and clog2 helper  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_LOCKED = 2'd3
   } arb_state_t;

   // Ceiling log2 for elaboration-time widths; clog2(1) == 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// +------------------------------------------------------------------+
// | uart_rr_pick : combinational round-robin picker (one-hot + index) |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (clog2(N) > 0) ? clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   // Walk offsets from far to near so the candidate closest to ptr is kept.
   always_comb begin
      int cand;
      cand  = 0;
      grant = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N;
         if (|(req & (N'(1) << cand))) begin
            grant = N'(1) << cand;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one UART TX between      |
// | NREQ byte requesters, with optional packet lock.  rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int PACKET_LOCK  = 1,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NREQ-1:0]               req_valid_i,
   input  logic [UART_DATA_W*NREQ-1:0]   req_data_i,
   input  logic [NREQ-1:0]               req_last_i,
   output logic [NREQ-1:0]               req_ack_o,
   output logic [UART_DATA_W-1:0]        uart_tx_data_o,
   output logic                          uart_tx_ready_o,
   input  logic                          uart_tx_ack_i,
   output logic [NREQ-1:0]               grant_o,
   output logic                          busy_o
);

   localparam int PTR_W = clog2(NREQ);
   localparam int CNT_W = (clog2(LOCK_TIMEOUT + 1) > 0) ? clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

   arb_state_t               r_state;
   arb_state_t               w_state_nx;
   logic [PTR_W-1:0]         r_ptr;
   logic [PTR_W-1:0]         r_owner;
   logic [UART_DATA_W-1:0]   r_data;
   logic                     r_last;
   logic [CNT_W-1:0]         r_cnt;

   logic [NREQ-1:0]          w_pick_grant;
   logic [PTR_W-1:0]         w_pick_idx;
   logic [NREQ-1:0]          w_owner_oh;
   logic                     w_owner_valid;
   logic [NREQ-1:0]          w_ack;
   logic [PTR_W-1:0]         w_cap_idx;
   logic [UART_DATA_W-1:0]   w_cap_data;
   logic                     w_capture;
   logic                     w_timeout;
   logic                     w_release;

   uart_rr_pick #(
      .N     (NREQ),
      .IDX_W (PTR_W)
   ) u_pick (
      .req   (req_valid_i),
      .ptr   (r_ptr),
      .grant (w_pick_grant),
      .idx   (w_pick_idx)
   );

   assign w_owner_oh    = NREQ'(1) << r_owner;
   assign w_owner_valid = |(req_valid_i & w_owner_oh);
   assign w_capture     = |w_ack;
   // Timeout fires on the cycle the idle count would reach LOCK_TIMEOUT.
   assign w_timeout     = (LOCK_TIMEOUT != 0) && !w_owner_valid && (r_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_release  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) w_state_nx = ST_SEND;
         end
         ST_SEND: begin
            if (uart_tx_ack_i) w_state_nx = ST_HOLD;
         end
         ST_HOLD: begin
            if (PACKET_LOCK == 0 || r_last) begin
               w_state_nx = ST_IDLE;
               w_release  = 1'b1;
            end else begin
               w_state_nx = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_capture) begin
               w_state_nx = ST_SEND;
            end else if (w_timeout) begin
               w_state_nx = ST_IDLE;
               w_release  = 1'b1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Acks and grant are forced low while reset is asserted so nothing
   // combinational leaks out of a block that is being cleared.
   always_comb begin
      w_ack           = '0;
      w_cap_idx       = r_owner;
      grant_o         = '0;
      uart_tx_ready_o = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ack     = w_pick_grant;
            w_cap_idx = w_pick_idx;
            grant_o   = w_pick_grant;
         end
         ST_SEND: begin
            uart_tx_ready_o = uart_tx_ack_i;
            grant_o         = w_owner_oh;
         end
         ST_HOLD: begin
            grant_o = w_owner_oh;
         end
         ST_LOCKED: begin
            grant_o = w_owner_oh;
            if (w_owner_valid) w_ack = w_owner_oh;
         end
         default: ;
      endcase
      if (reset) begin
         w_ack   = '0;
         grant_o = '0;
      end
   end

   always_comb begin
      w_cap_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_ack[i]) w_cap_data = req_data_i[i*UART_DATA_W +: UART_DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_capture) begin
            r_owner <= w_cap_idx;
            r_data  <= w_cap_data;
            r_last  <= |(req_last_i & w_ack);
         end
         if (w_release) begin
            r_ptr <= (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
         end
         if (r_state == ST_HOLD) begin
            r_cnt <= '0;
         end else if (r_state == ST_LOCKED && !w_owner_valid && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign req_ack_o      = w_ack;
   assign uart_tx_data_o = r_data;
   assign busy_o         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed self-checking bench for the arbiter |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  valid = '0;
   logic [31:0] data = '0;
   logic [3:0]  last = '0;
   logic        uack = 1'b0;

   logic [3:0]  ack, grant, nl_ack, nl_grant;
   logic [7:0]  txd, nl_txd;
   logic        ready, busy, nl_ready, nl_busy;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .PACKET_LOCK(1), .LOCK_TIMEOUT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid_i     (valid),
      .req_data_i      (data),
      .req_last_i      (last),
      .req_ack_o       (ack),
      .uart_tx_data_o  (txd),
      .uart_tx_ready_o (ready),
      .uart_tx_ack_i   (uack),
      .grant_o         (grant),
      .busy_o          (busy)
   );

   uart_tx_arbiter #(.NREQ(4), .PACKET_LOCK(0), .LOCK_TIMEOUT(8)) dut_nl (
      .clk             (clk),
      .reset           (reset),
      .req_valid_i     (valid),
      .req_data_i      (data),
      .req_last_i      (last),
      .req_ack_o       (nl_ack),
      .uart_tx_data_o  (nl_txd),
      .uart_tx_ready_o (nl_ready),
      .uart_tx_ack_i   (uack),
      .grant_o         (nl_grant),
      .busy_o          (nl_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic look;
      #2;
   endtask

   task automatic do_reset;
      valid = '0;
      last  = '0;
      data  = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset;
      look;
      chk("rst_ack",   ack,   0);
      chk("rst_grant", grant, 0);
      chk("rst_busy",  busy,  0);
      chk("rst_ready", ready, 0);
      chk("rst_data",  txd,   0);

      // Single request, req0 0x41 last
      nxt;
      uack = 1'b1;
      valid = 4'b0001; data[7:0] = 8'h41; last = 4'b0001;
      look;
      chk("t1_ack",   ack,   4'b0001);
      chk("t1_grant", grant, 4'b0001);
      chk("t1_busy0", busy,  0);
      nxt;
      valid = '0;
      look;
      chk("t1_strobe", {ready, txd}, {1'b1, 8'h41});
      chk("t1_busy1",  busy, 1);
      nxt; look;
      chk("t1_hold", {busy, ready}, 2'b10);
      nxt; look;
      chk("t1_idle",  {busy, grant}, 5'b0_0000);
      valid = 4'b0011;
      look;
      chk("t1_ptr1", ack, 4'b0010);

      // Fairness on the unlocked instance
      do_reset;
      uack = 1'b1;
      last = 4'b0000;
      data = 32'hA3A2A1A0;
      valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         look;
         chk("fair_ack", nl_ack, 4'b0001 << (k % 4));
         nxt; look;
         chk("fair_tx", {nl_ready, nl_txd, nl_grant}, {1'b1, 8'hA0 + 8'(k % 4), 4'b0001 << (k % 4)});
         nxt;
         nxt;
      end

      // Packet lock: req2 three bytes while req0/req1 wait
      do_reset;
      uack = 1'b1;
      valid = 4'b0100; data[23:16] = 8'h10; last = 4'b0000;
      look;
      chk("pl_ack0", ack, 4'b0100);
      nxt;
      valid = 4'b0111; data[23:16] = 8'h11;
      look;
      chk("pl_tx0", {ready, txd, ack}, {1'b1, 8'h10, 4'b0000});
      nxt; look;
      chk("pl_hold0", {ready, ack}, 5'b0_0000);
      nxt; look;
      chk("pl_ack1", {ack, grant}, {4'b0100, 4'b0100});
      nxt;
      data[23:16] = 8'h12; last = 4'b0100;
      look;
      chk("pl_tx1", {ready, txd}, {1'b1, 8'h11});
      nxt; look;
      chk("pl_hold1", ack, 4'b0000);
      nxt; look;
      chk("pl_ack2", ack, 4'b0100);
      nxt;
      valid = 4'b0011;
      look;
      chk("pl_tx2", {ready, txd}, {1'b1, 8'h12});
      nxt; look;
      chk("pl_hold2", {busy, ack}, 5'b1_0000);
      nxt; look;
      chk("pl_next", {busy, ack}, 5'b0_0001);

      // Lock timeout
      do_reset;
      uack = 1'b1;
      valid = 4'b0010; data[15:8] = 8'h55; last = 4'b0000;
      look;
      chk("to_ack1", ack, 4'b0010);
      nxt;
      valid = 4'b0001; data[7:0] = 8'h66; last = 4'b0001;
      look;
      chk("to_tx", {ready, txd}, {1'b1, 8'h55});
      nxt; look;
      chk("to_hold", ack, 4'b0000);
      nxt;
      for (int i = 0; i < 8; i++) begin
         look;
         chk("to_locked", {busy, ack, grant}, {1'b1, 4'b0000, 4'b0010});
         nxt;
      end
      look;
      chk("to_release", {busy, ack}, 5'b0_0001);

      // UART backpressure
      do_reset;
      uack = 1'b0;
      valid = 4'b1000; data[31:24] = 8'h5A; last = 4'b1000;
      look;
      chk("bp_ack3", ack, 4'b1000);
      nxt;
      valid = '0;
      for (int i = 0; i < 100; i++) begin
         look;
         chk("bp_wait", {busy, ready, txd}, {1'b1, 1'b0, 8'h5A});
         nxt;
      end
      uack = 1'b1;
      look;
      chk("bp_strobe", {ready, txd}, {1'b1, 8'h5A});
      nxt; look;
      chk("bp_hold", {busy, ready}, 2'b10);
      nxt; look;
      chk("bp_idle", busy, 0);

      // Asynchronous reset while in SEND
      do_reset;
      uack = 1'b0;
      valid = 4'b0100; data[23:16] = 8'h77; last = 4'b0100;
      look;
      chk("ar_ack", ack, 4'b0100);
      nxt; look;
      chk("ar_send", {busy, txd}, {1'b1, 8'h77});
      #1 reset = 1'b1;
      #1;
      chk("ar_out", {ack, grant, busy, ready, txd}, 18'h0);
      valid = '0;
      uack = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nxt; look;
         chk("ar_quiet", {busy, ready}, 2'b00);
      end
      valid = 4'b0101;
      look;
      chk("ar_next", ack, 4'b0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single UART transmitter among NREQ byte requesters (e.g. command responder, debug dump, loopback echo). It sits between the requesters and the UART's tx_data_i / tx_ready_i / tx_ack_o port and sequences one byte at a time onto it. Optional packet lock keeps the grant on one requester until it marks the last byte, so multi-byte messages are never interleaved.

## Interface
- NREQ, 4: number of requesters, 2..8.
- PACKET_LOCK, 1: 1 holds the grant until a byte with last set; 0 re-arbitrates after every byte.
- LOCK_TIMEOUT, 1024: idle cycles a locked owner may leave req_valid_i low before the lock is dropped; 0 means never time out.
- clk  in  1  system clock; one clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  NREQ  requester i has a byte; held until acked.
- req_data_i  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_last_i  in  NREQ  byte is last of its packet; sampled with data.
- req_ack_o  out  NREQ  one-cycle pulse: byte of requester i captured.
- uart_tx_data_o  out  8  byte to UART, stable while in SEND.
- uart_tx_ready_o  out  1  one-cycle load strobe to UART.
- uart_tx_ack_i  in  1  UART transmitter idle, can accept a byte.
- grant_o  out  NREQ  one-hot current owner, 0 when none.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SEND, HOLD, LOCKED. Reset to IDLE.
- IDLE: if any req_valid_i, pick winner i by round-robin from priority pointer. In the same cycle, pulse req_ack_o[i], capture data and last into a holding register, set grant_o to i. Next state SEND.
- Round-robin: search starts at pointer and wraps modulo NREQ. Pointer becomes (i+1) mod NREQ when the grant is released, not per byte.
- SEND: uart_tx_data_o = held byte. uart_tx_ready_o = uart_tx_ack_i, i.e. the strobe fires in the first cycle ack is high. On the strobe, next state HOLD; otherwise stay.
- HOLD: one-cycle holdoff; uart_tx_ack_i is ignored while the UART deasserts it.
  - If PACKET_LOCK=0 or held last=1: release grant, advance pointer, go to IDLE.
  - Otherwise go to LOCKED and clear the timeout counter.
- LOCKED: only owner i is eligible. If req_valid_i[i]: ack, capture, SEND. Other requesters are never acked here.
  - Timeout counter increments each cycle owner valid is low.
  - When counter reaches LOCK_TIMEOUT (non-zero): release, advance pointer, go to IDLE.
  - If owner valid and timeout occur in the same cycle, capture wins.
- Timeout counter width is clog2(LOCK_TIMEOUT+1) and saturates; it never wraps.
- Exactly one req_ack_o bit is high at a time; exactly one uart_tx_ready_o pulse per ack.
- Reset mid-operation: all state cleared immediately. A byte already acked but not strobed is discarded.

## Timing
- Reset values: req_ack_o=0, uart_tx_data_o=0x00, uart_tx_ready_o=0, grant_o=0, busy_o=0, pointer=0, counter=0.
- req_ack_o is combinational from req_valid_i and the registered state/pointer. There is no combinational path from uart_tx_ack_i to req_ack_o.
- Capture in cycle C gives the earliest strobe at C+1, if uart_tx_ack_i is high.
- Minimum per-byte period is 3 cycles (capture, SEND, HOLD) plus the UART frame time.
- A new requester raising valid while IDLE is acked the same cycle.

## Structure
- Shared package uart_pkg: UART_DATA_W=8, the arbiter state enum, and a clog2 helper function.
- One sub-module, uart_rr_pick: combinational round-robin picker. Inputs are the request vector and pointer; outputs are the one-hot grant and the winner index. Reusable for a future RX dispatcher.

## Test plan
- Single request: req0 sends 0x41 with last=1 and uart ack held high. Expect ack0 at C, uart_tx_ready_o with data 0x41 at C+1, IDLE at C+3, pointer=1.
- Fairness: all 4 requesters continuously valid, PACKET_LOCK=0. Expect grant order 0,1,2,3,0 and one byte each per rotation.
- Packet lock: req2 sends 3 bytes 0x10,0x11,0x12(last) while req0/req1 are valid. Expect all three req2 bytes sent contiguously, then grant to req3 if valid, else req0.
- Lock timeout: LOCK_TIMEOUT=8, req1 sends a non-last byte then drops valid. Expect release exactly 8 cycles after entering LOCKED, then req0 (waiting) is acked next.
- UART backpressure: uart_tx_ack_i held low for 100 cycles in SEND. Expect no strobe and uart_tx_data_o stable; strobe fires in the first cycle ack returns high.
- Async reset in SEND: assert reset between clock edges. Expect all outputs 0 immediately, no strobe afterwards, and the next grant goes to req0.
